uart_tx_periph: RTL and testbench
=================================

Name: uart_tx_periph

Overview:
Memory-mapped UART transmitter on the core data port, beside the cache bus. It replaces the simulation-only character dump at 0x40000004 with a real serial line. Byte writes go into a TX FIFO and are shifted out as 8N1 frames on `tx`. The top level steers bus read/write away from the cache whenever `selected` is high, and muxes `data_out`/`data_ready` into the core.

Parameters:
TX_ADDR, 32'h40000004, write-only transmit data register
STATUS_ADDR, 32'h4000000C, read-only status register
CLOCKS_PER_BIT, 100, clock cycles per serial bit (minimum 2)
FIFO_DEPTH_LOG2, 4, FIFO depth = 2**FIFO_DEPTH_LOG2 bytes

Ports:
clock  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high
data_address  input  32  core data address
data_width  input  2  access width (ignored)
data_in  input  32  core write data; only [7:0] is used
data_read  input  1  core read request
data_write  input  1  core write request
data_out  output  32  registered read data
data_ready  output  1  registered access-complete pulse
selected  output  1  combinational: data_address == TX_ADDR or STATUS_ADDR
tx  output  1  serial line, idles high
busy  output  1  FIFO non-empty or frame in progress

Behaviour:
- Reset (synchronous, active-high; clock is `clock`):
  - tx=1, data_ready=0, data_out=0, busy=0.
  - FIFO flushed, FSM=IDLE, baud and bit counters cleared.
  - Reset mid-frame aborts the frame: tx is high after that edge and queued bytes are lost.
- Access acceptance:
  - A request (data_read or data_write) with `selected` high is accepted on an edge only if data_ready==0 at that edge.
  - data_ready=1 on the cycle after acceptance, for exactly one cycle.
  - Minimum spacing between accepted accesses is therefore 2 cycles. A request held high through its ready cycle is not double-accepted.
  - Unselected addresses: no state change; data_ready stays 0; data_out is 0.
- Write TX_ADDR:
  - Accepted when FIFO count < depth, using the registered count from before the edge; data_in[7:0] is pushed.
  - When the FIFO is full the request stalls: no push, data_ready stays 0.
  - The write is accepted on the first edge with count < depth. A pop on the same edge does not unblock it; acceptance happens one edge later.
- Write STATUS_ADDR: accepted with a ready pulse, no effect.
- Read STATUS_ADDR: data_out latched at acceptance.
  - [0] busy
  - [1] full
  - [2] empty
  - [15:8] count
  - others 0
- Read TX_ADDR: returns 0.
- FIFO:
  - Circular buffer with FIFO_DEPTH_LOG2-bit pointers that wrap modulo depth.
  - Count width is FIFO_DEPTH_LOG2+1.
  - Simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP. The baud counter runs 0..CLOCKS_PER_BIT-1.
  - IDLE: if FIFO is non-empty, pop into the shift register, go to START, tx<=0.
  - START: after CLOCKS_PER_BIT cycles go to DATA with bit index 0; tx<=shift[0].
  - DATA: sends bits LSB first, each held CLOCKS_PER_BIT cycles. After bit 7 go to STOP with tx<=1.
  - STOP: held CLOCKS_PER_BIT cycles.
    - If the FIFO is non-empty at the end, pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- Latency and timing:
  - A write accepted at edge N into an empty, idle block pushes at N; the pop and tx falling happen at edge N+1.
  - A frame is 10*CLOCKS_PER_BIT cycles.
- busy is registered: (FSM != IDLE) or (count != 0).

Test Plan:
1. Reset, then read STATUS_ADDR -> data_ready pulses 1 cycle later, data_out=32'h00000004, tx=1, busy=0.
2. CLOCKS_PER_BIT=4, write 32'h000000A5 to TX_ADDR -> tx low for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high 4 cycles; 40 cycles total; busy falls after stop.
3. Depth 16, write bytes 0x00..0x11 with minimum spacing -> 17 writes complete without stall; the 18th holds data_ready low until frame 0x00 finishes its stop bit; the line carries 0x00..0x11 in order, with no gaps between frames.
4. Queue 3 bytes, read status during the first frame -> data_out=32'h00000201 (count 2, busy 1); after the last frame, status reads 32'h00000004.
5. Assert reset during the DATA bits of a frame with 5 bytes queued -> tx=1 on the next cycle, status reads 32'h00000004, no further frames.
6. Write to 32'h40000008 and read 32'h40000004 -> selected=0 for the first, no push, no ready; the second gives a ready pulse with data_out=0.

Source files
------------

// File: rtl/uart_tx_periph_if.sv
// rtl/uart_tx_periph_if.sv - core data-port bus bundle for the memory-mapped UART transmitter
interface uart_tx_periph_if;
    logic [31:0] data_address;
    logic [1:0]  data_width;
    logic [31:0] data_in;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_out;
    logic        data_ready;
    logic        selected;

    modport master (
        output data_address, data_width, data_in, data_read, data_write,
        input  data_out, data_ready, selected
    );

    modport slave (
        input  data_address, data_width, data_in, data_read, data_write,
        output data_out, data_ready, selected
    );
endinterface

// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - memory-mapped 8N1 UART transmitter with byte FIFO and status register
module uart_tx_periph #(
    parameter logic [31:0] TX_ADDR         = 32'h40000004,
    parameter logic [31:0] STATUS_ADDR     = 32'h4000000C,
    parameter int          CLOCKS_PER_BIT  = 100,
    parameter int          FIFO_DEPTH_LOG2 = 4
) (
    input  logic           clock,
    input  logic           reset,
    uart_tx_periph_if.slave bus,
    output logic           tx,
    output logic           busy
);
    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int BW    = $clog2(CLOCKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t state, state_next;
    logic [BW-1:0] baud, baud_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shift, shift_next;
    logic          tx_next;
    logic          pop;

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]              count, count_next;
    logic                       full, empty;

    logic is_tx, is_status, req, stall, accept, push, rd_status;
    logic [31:0] status_word;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.data_width, bus.data_in[31:8]};

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign is_tx        = (bus.data_address == TX_ADDR);
    assign is_status    = (bus.data_address == STATUS_ADDR);
    assign bus.selected = is_tx | is_status;

    // A full FIFO stalls only TX writes; the decision uses the count from before the edge.
    assign req         = bus.data_read | bus.data_write;
    assign stall       = bus.data_write & is_tx & full;
    assign accept      = req & bus.selected & ~bus.data_ready & ~stall;
    assign push        = accept & bus.data_write & is_tx;
    assign rd_status   = accept & bus.data_read & ~bus.data_write & is_status;
    assign status_word = {16'b0, 8'(count), 5'b0, empty, full, busy};

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= bus.data_in[7:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.data_ready <= 1'b0;
            bus.data_out   <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            busy           <= 1'b0;
        end else begin
            bus.data_ready <= accept;
            bus.data_out   <= rd_status ? status_word : 32'h0;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            busy  <= (state_next != IDLE) || (count_next != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_next;
            shift   <= shift_next;
            tx      <= tx_next;
        end
    end

    // The shift register is consumed LSB first by shifting right after each data bit.
    always_comb begin
        state_next = state;
        baud_next  = baud;
        bit_next   = bit_idx;
        shift_next = shift;
        tx_next    = tx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    state_next = START;
                    baud_next  = '0;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (baud == BAUD_LAST) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                    tx_next    = shift[0];
                end else begin
                    baud_next = baud + BW'(1);
                end
            end
            DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next   = bit_idx + 3'd1;
                        shift_next = {1'b0, shift[7:1]};
                        tx_next    = shift[1];
                    end
                end else begin
                    baud_next = baud + BW'(1);
                end
            end
            STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_next = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud + BW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_periph.sv
// tb/tb_uart_tx_periph.sv - scoreboard bench for uart_tx_periph with a serial line decoder
module tb_uart_tx_periph;
    localparam int CPB = 4;
    localparam logic [31:0] TX_ADDR     = 32'h40000004;
    localparam logic [31:0] STATUS_ADDR = 32'h4000000C;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tx, busy;

    uart_tx_periph_if bus ();

    uart_tx_periph #(
        .TX_ADDR(TX_ADDR),
        .STATUS_ADDR(STATUS_ADDR),
        .CLOCKS_PER_BIT(CPB),
        .FIFO_DEPTH_LOG2(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .tx(tx),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0] expq[$];
    int starts[$];
    int frames = 0;
    bit mon_abort = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Line decoder: aligns on the start bit, samples every cycle of the frame.
    logic [9:0] slot;
    bit steady, aborted;
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && !mon_abort && tx === 1'b0) begin
                starts.push_back(cyc);
                frames++;
                steady  = 1'b1;
                aborted = 1'b0;
                slot    = '0;
                for (int k = 0; k < 10 * CPB; k++) begin
                    if (k > 0) @(negedge clock);
                    if (mon_abort || reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k % CPB == 0) slot[k / CPB] = tx;
                    else if (tx !== slot[k / CPB]) steady = 1'b0;
                end
                if (!aborted) begin
                    check("bit_steady", 32'(steady), 32'd1);
                    check("start_stop", 32'({slot[9], slot[0]}), 32'd2);
                    if (expq.size() == 0)
                        check("frame_expected", 32'(expq.size()), 32'd1);
                    else
                        check("frame_byte", 32'(slot[8:1]), 32'(expq.pop_front()));
                end
            end
        end
    end

    task automatic bus_access(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                              input bit hold, output logic [31:0] rdata, output int waited);
        bit accepted = 1'b0;
        bus.data_address = addr;
        bus.data_in      = wdata;
        bus.data_write   = wr;
        bus.data_read    = !wr;
        waited = 0;
        rdata  = '0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clock);
            #1;
            waited++;
            if (bus.data_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted)
            check("access_timeout", 32'(accepted), 32'd1);
        else if (wr && addr == TX_ADDR)
            expq.push_back(wdata[7:0]);
        rdata = bus.data_out;
        if (!hold) begin
            bus.data_read  = 1'b0;
            bus.data_write = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!busy && expq.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [31:0] rd;
    int w, t0, max_wait, acc, fb;
    initial begin
        bus.data_address = '0;
        bus.data_width   = 2'b10;
        bus.data_in      = '0;
        bus.data_read    = 1'b0;
        bus.data_write   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bus.data_ready), 32'd0);
        check("rst_dout", bus.data_out, 32'd0);
        reset = 1'b0;

        bus_access(STATUS_ADDR, 1'b0, 32'h0, 1'b1, rd, w);
        check("t1_latency", 32'(w), 32'd1);
        check("t1_status", rd, 32'h00000004);
        check("t1_tx", 32'(tx), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        @(posedge clock);
        #1;
        check("t1_single_pulse", 32'(bus.data_ready), 32'd0);
        bus.data_read = 1'b0;
        @(posedge clock);
        #1;

        starts.delete();
        bus_access(TX_ADDR, 1'b1, 32'h000000A5, 1'b0, rd, w);
        check("t2_latency", 32'(w), 32'd1);
        check("t2_tx_before", 32'(tx), 32'd1);
        t0 = cyc;
        @(posedge clock);
        #1;
        check("t2_tx_fall", 32'(tx), 32'd0);
        check("t2_busy_mid", 32'(busy), 32'd1);
        repeat (39) @(posedge clock);
        #1;
        check("t2_busy_stop", 32'(busy), 32'd1);
        @(posedge clock);
        #1;
        check("t2_frame_len", 32'(cyc - t0), 32'd41);
        check("t2_busy_end", 32'(busy), 32'd0);
        check("t2_frames", 32'(starts.size()), 32'd1);
        check("t2_drained", 32'(expq.size()), 32'd0);

        starts.delete();
        max_wait = 0;
        for (int i = 0; i < 17; i++) begin
            bus_access(TX_ADDR, 1'b1, 32'(i), 1'b0, rd, w);
            if (w > max_wait) max_wait = w;
        end
        check("t3_no_stall", 32'(max_wait), 32'd2);
        bus_access(TX_ADDR, 1'b1, 32'h11, 1'b0, rd, w);
        acc = cyc;
        if (starts.size() == 0)
            check("t3_started", 32'(starts.size()), 32'd1);
        else
            check("t3_stall_release", 32'(acc), 32'(starts[0] + 41));
        wait_idle("t3_idle");
        check("t3_frames", 32'(starts.size()), 32'd18);
        for (int i = 1; i < starts.size(); i++)
            check("t3_gap", 32'(starts[i] - starts[i-1]), 32'(10 * CPB));

        starts.delete();
        bus_access(TX_ADDR, 1'b1, 32'h3C, 1'b0, rd, w);
        bus_access(TX_ADDR, 1'b1, 32'hC3, 1'b0, rd, w);
        bus_access(TX_ADDR, 1'b1, 32'h5A, 1'b0, rd, w);
        bus_access(STATUS_ADDR, 1'b0, 32'h0, 1'b0, rd, w);
        check("t4_status_mid", rd, 32'h00000201);
        wait_idle("t4_idle");
        bus_access(STATUS_ADDR, 1'b0, 32'h0, 1'b0, rd, w);
        check("t4_status_end", rd, 32'h00000004);
        check("t4_frames", 32'(starts.size()), 32'd3);

        starts.delete();
        for (int i = 0; i < 5; i++)
            bus_access(TX_ADDR, 1'b1, 32'(8'h90 + i), 1'b0, rd, w);
        for (int i = 0; i < 200 && starts.size() == 0; i++) begin
            @(posedge clock);
            #1;
        end
        check("t5_started", 32'(starts.size()), 32'd1);
        repeat (10) @(posedge clock);
        #1;
        mon_abort = 1'b1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("t5_tx_reset", 32'(tx), 32'd1);
        check("t5_busy_reset", 32'(busy), 32'd0);
        reset = 1'b0;
        expq.delete();
        repeat (2) @(posedge clock);
        #1;
        mon_abort = 1'b0;
        fb = frames;
        bus_access(STATUS_ADDR, 1'b0, 32'h0, 1'b0, rd, w);
        check("t5_status", rd, 32'h00000004);
        repeat (100) @(posedge clock);
        #1;
        check("t5_no_frames", 32'(frames - fb), 32'd0);
        check("t5_tx_idle", 32'(tx), 32'd1);

        fb = frames;
        bus.data_address = 32'h40000008;
        bus.data_in      = 32'h77;
        bus.data_write   = 1'b1;
        #1;
        check("t6_selected", 32'(bus.selected), 32'd0);
        max_wait = 0;
        repeat (4) begin
            @(posedge clock);
            #1;
            if (bus.data_ready) max_wait++;
        end
        check("t6_no_ready", 32'(max_wait), 32'd0);
        check("t6_dout", bus.data_out, 32'd0);
        bus.data_write = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("t6_no_push", 32'(busy), 32'd0);
        check("t6_no_frame", 32'(frames - fb), 32'd0);
        bus_access(TX_ADDR, 1'b0, 32'h0, 1'b0, rd, w);
        check("t6_tx_read_latency", 32'(w), 32'd1);
        check("t6_tx_read", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
